// File: rtl/interp_sweep_ctrl.sv
// Sweep sequencer for the LUT-interpolation datapath: steps x through a range,
// captures linear/quadratic/exact results and tracks worst-case error per method.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start after reset
// WAIT    | x_input applied, counting out datapath latency
// CAPTURE | datapath outputs valid; next edge samples errors and updates maxima
// DONE    | sweep finished; results held until the next accepted start
module interp_sweep_ctrl #(
   parameter int LATENCY = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] x_start,
   input  logic [7:0] x_end,
   output logic [7:0] x_input,
   input  logic [7:0] y_output_linear,
   input  logic [7:0] y_output_quadratic,
   input  logic [7:0] y_output_exact,
   output logic       busy,
   output logic       done,
   output logic       sample_valid,
   output logic [7:0] sample_x,
   output logic [7:0] err_lin,
   output logic [7:0] err_quad,
   output logic [7:0] max_err_lin,
   output logic [7:0] max_err_quad,
   output logic [7:0] max_x_lin,
   output logic [7:0] max_x_quad
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] x_end_q, x_end_d;
   logic [7:0] x_in_q, x_in_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       sv_q, sv_d;
   logic [7:0] sample_x_q, sample_x_d;
   logic [7:0] err_lin_q, err_lin_d;
   logic [7:0] err_quad_q, err_quad_d;
   logic [7:0] max_lin_q, max_lin_d;
   logic [7:0] max_quad_q, max_quad_d;
   logic [7:0] max_x_lin_q, max_x_lin_d;
   logic [7:0] max_x_quad_q, max_x_quad_d;
   logic [7:0] diff_lin, diff_quad;

   function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   assign diff_lin  = abs_diff(y_output_linear, y_output_exact);
   assign diff_quad = abs_diff(y_output_quadratic, y_output_exact);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      x_end_d      = x_end_q;
      x_in_d       = x_in_q;
      busy_d       = busy_q;
      done_d       = done_q;
      sv_d         = 1'b0;
      sample_x_d   = sample_x_q;
      err_lin_d    = err_lin_q;
      err_quad_d   = err_quad_q;
      max_lin_d    = max_lin_q;
      max_quad_d   = max_quad_q;
      max_x_lin_d  = max_x_lin_q;
      max_x_quad_d = max_x_quad_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               x_end_d      = x_end;
               x_in_d       = x_start;
               cnt_d        = 4'd0;
               max_lin_d    = 8'd0;
               max_quad_d   = 8'd0;
               max_x_lin_d  = 8'd0;
               max_x_quad_d = 8'd0;
               done_d       = 1'b0;
               busy_d       = 1'b1;
               state_d      = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAT_M1) state_d = CAPTURE;
         end
         CAPTURE: begin
            sample_x_d = x_in_q;
            err_lin_d  = diff_lin;
            err_quad_d = diff_quad;
            sv_d       = 1'b1;
            // strict compare: on a tie the earlier x is kept
            if (diff_lin > max_lin_q) begin
               max_lin_d   = diff_lin;
               max_x_lin_d = x_in_q;
            end
            if (diff_quad > max_quad_q) begin
               max_quad_d   = diff_quad;
               max_x_quad_d = x_in_q;
            end
            if (x_in_q == x_end_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               x_in_d  = x_in_q + 8'd1;
               cnt_d   = 4'd0;
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         x_end_q      <= 8'd0;
         x_in_q       <= 8'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         sv_q         <= 1'b0;
         sample_x_q   <= 8'd0;
         err_lin_q    <= 8'd0;
         err_quad_q   <= 8'd0;
         max_lin_q    <= 8'd0;
         max_quad_q   <= 8'd0;
         max_x_lin_q  <= 8'd0;
         max_x_quad_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         x_end_q      <= x_end_d;
         x_in_q       <= x_in_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         sv_q         <= sv_d;
         sample_x_q   <= sample_x_d;
         err_lin_q    <= err_lin_d;
         err_quad_q   <= err_quad_d;
         max_lin_q    <= max_lin_d;
         max_quad_q   <= max_quad_d;
         max_x_lin_q  <= max_x_lin_d;
         max_x_quad_q <= max_x_quad_d;
      end
   end

   assign x_input      = x_in_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign sample_valid = sv_q;
   assign sample_x     = sample_x_q;
   assign err_lin      = err_lin_q;
   assign err_quad     = err_quad_q;
   assign max_err_lin  = max_lin_q;
   assign max_err_quad = max_quad_q;
   assign max_x_lin    = max_x_lin_q;
   assign max_x_quad   = max_x_quad_q;

endmodule

// File: tb/tb_interp_sweep_ctrl.sv
// Directed bench for interp_sweep_ctrl: table of sweeps against a small datapath
// model with injected errors, plus reset-abort and mid-sweep start sequences.
module tb_interp_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] x_start, x_end;
   logic [7:0] x_input;
   logic [7:0] y_lin, y_quad, y_exact;
   logic       busy, done, sample_valid;
   logic [7:0] sample_x, err_lin, err_quad;
   logic [7:0] max_err_lin, max_err_quad, max_x_lin, max_x_quad;

   int errors = 0;
   int checks = 0;
   int mode   = 0;

   always #5 clk = ~clk;

   interp_sweep_ctrl #(.LATENCY(2)) dut (
      .clk(clk), .rst(rst), .start(start), .x_start(x_start), .x_end(x_end),
      .x_input(x_input), .y_output_linear(y_lin), .y_output_quadratic(y_quad),
      .y_output_exact(y_exact), .busy(busy), .done(done), .sample_valid(sample_valid),
      .sample_x(sample_x), .err_lin(err_lin), .err_quad(err_quad),
      .max_err_lin(max_err_lin), .max_err_quad(max_err_quad),
      .max_x_lin(max_x_lin), .max_x_quad(max_x_quad)
   );

   // datapath model: exact = x/2, with per-mode signed deviations injected
   function automatic int lin_dev(input int m, input int x);
      case (m)
         1: return (x == 181) ? 3 : (x == 182) ? 5 : 0;
         2: return (x == 10) ? 4 : (x == 12) ? -4 : 0;
         3: return (x == 255) ? -6 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic int quad_dev(input int m, input int x);
      case (m)
         1: return (x == 183) ? -2 : 0;
         2: return (x == 11) ? 1 : 0;
         3: return (x == 0) ? 7 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   always_comb begin
      y_exact = x_input >> 1;
      y_lin   = 8'(int'(y_exact) + lin_dev(mode, int'(x_input)));
      y_quad  = 8'(int'(y_exact) + quad_dev(mode, int'(x_input)));
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int xs;
      int xe;
      int m;
      int npts;
      int mel;
      int mxl;
      int meq;
      int mxq;
      bit mid_start;
   } vec_t;

   task automatic run_sweep(input vec_t v);
      int k;
      int xexp;
      mode    = v.m;
      x_start = 8'(v.xs);
      x_end   = 8'(v.xe);
      start   = 1'b1;
      tick();
      start   = 1'b0;
      chk("busy_after_start", int'(busy), 1);
      chk("done_after_start", int'(done), 0);
      k = 0;
      for (int cyc = 1; cyc <= 3 * v.npts + 6 && k < v.npts; cyc++) begin
         if (v.mid_start && cyc == 4) begin
            start   = 1'b1;
            x_start = 8'd99;
            x_end   = 8'd99;
         end else begin
            start = 1'b0;
         end
         tick();
         if (sample_valid) begin
            xexp = (v.xs + k) % 256;
            chk("pulse_cycle", cyc, 3 * (k + 1));
            chk("sample_x", int'(sample_x), xexp);
            chk("err_lin", int'(err_lin), iabs(lin_dev(v.m, xexp)));
            chk("err_quad", int'(err_quad), iabs(quad_dev(v.m, xexp)));
            chk("done_with_pulse", int'(done), (k == v.npts - 1) ? 1 : 0);
            chk("busy_with_pulse", int'(busy), (k == v.npts - 1) ? 0 : 1);
            k++;
         end
      end
      start = 1'b0;
      chk("point_count", k, v.npts);
      chk("max_err_lin", int'(max_err_lin), v.mel);
      chk("max_x_lin", int'(max_x_lin), v.mxl);
      chk("max_err_quad", int'(max_err_quad), v.meq);
      chk("max_x_quad", int'(max_x_quad), v.mxq);
      tick();
      chk("pulse_single", int'(sample_valid), 0);
      chk("done_held", int'(done), 1);
      chk("x_input_held", int'(x_input), v.xe);
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{xs: 180, xe: 183, m: 0, npts: 4, mel: 0, mxl: 0,   meq: 0, mxq: 0,   mid_start: 0};
      vecs[1] = '{xs: 180, xe: 183, m: 1, npts: 4, mel: 5, mxl: 182, meq: 2, mxq: 183, mid_start: 0};
      vecs[2] = '{xs: 254, xe: 1,   m: 3, npts: 4, mel: 6, mxl: 255, meq: 7, mxq: 0,   mid_start: 0};
      vecs[3] = '{xs: 7,   xe: 7,   m: 0, npts: 1, mel: 0, mxl: 0,   meq: 0, mxq: 0,   mid_start: 0};
      vecs[4] = '{xs: 8,   xe: 13,  m: 2, npts: 6, mel: 4, mxl: 10,  meq: 1, mxq: 11,  mid_start: 1};

      rst = 1'b1; start = 1'b0; x_start = 8'd0; x_end = 8'd0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_x_input", int'(x_input), 0);
      chk("rst_sample_valid", int'(sample_valid), 0);

      foreach (vecs[i]) run_sweep(vecs[i]);

      // abort a sweep during the second point's wait, then rerun cleanly
      mode = 1; x_start = 8'd181; x_end = 8'd183; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 10 && !sample_valid; c++) tick();
      chk("abort_first_pulse", int'(sample_valid), 1);
      chk("abort_first_max", int'(max_err_lin), 3);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_x_input", int'(x_input) + int'(sample_x) + int'(err_lin) + int'(err_quad), 0);
      chk("abort_max", int'(max_err_lin) + int'(max_x_lin) + int'(max_err_quad) + int'(max_x_quad), 0);
      chk("abort_flags", int'(done) + int'(sample_valid), 0);
      tick();
      chk("abort_idle", int'(busy) + int'(sample_valid), 0);
      run_sweep('{xs: 181, xe: 183, m: 0, npts: 3, mel: 0, mxl: 0, meq: 0, mxq: 0, mid_start: 0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/interp_sweep_ctrl.md
Name: interp_sweep_ctrl

Overview:
Sequencer that drives the LUT-interpolation datapath (Main) through a programmable range of x values. For each x it waits out the datapath latency, captures the linear, quadratic and exact outputs, and computes absolute errors. It also tracks the worst-case error for each method across the sweep. It replaces free-running testbench stimulus with a controlled, repeatable characterisation sweep that lives on-chip next to Main.

Parameters:
LATENCY, 2, clock cycles from an x_input change until Main outputs are valid (legal range 1..15)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle sweep request; ignored while busy=1
x_start  input  8  first x of sweep; latched on accepted start
x_end  input  8  last x of sweep; latched on accepted start
x_input  output  8  x value driven to Main
y_output_linear  input  8  Main linear-interpolation result
y_output_quadratic  input  8  Main quadratic-interpolation result
y_output_exact  input  8  Main exact result
busy  output  1  sweep in progress
done  output  1  sweep complete; held until next accepted start or rst
sample_valid  output  1  one-cycle pulse per captured point
sample_x  output  8  x of the captured point
err_lin  output  8  |linear - exact| of the captured point
err_quad  output  8  |quadratic - exact| of the captured point
max_err_lin  output  8  running maximum of err_lin this sweep
max_err_quad  output  8  running maximum of err_quad this sweep
max_x_lin  output  8  x where max_err_lin first reached its current value
max_x_quad  output  8  x where max_err_quad first reached its current value

Behaviour:
- Reset: every output and internal register is 0 and the state is IDLE. rst overrides start, including mid-sweep; the sweep is abandoned within one edge.
- States: IDLE, WAIT, CAPTURE, DONE.
- IDLE/DONE, start=1:
  - latch x_start/x_end
  - x_input<=x_start; wait counter<=0
  - clear max_* registers and done
  - busy<=1; go to WAIT
- WAIT: counter increments each edge. At the edge where counter==LATENCY-1, go to CAPTURE.
- CAPTURE edge:
  - sample the three y inputs
  - sample_x<=x_input
  - err_lin/err_quad<=8-bit unsigned absolute difference vs exact (no overflow possible)
  - sample_valid<=1 for exactly one cycle
- Max update: a max_err register takes the new error only if it is strictly greater, and its max_x is updated with it. Ties keep the earlier x.
- Max same-edge rule: on the CAPTURE edge, max_err outputs already include that same point.
- After CAPTURE:
  - if x_input==x_end: go to DONE, busy<=0, done<=1 (done rises with the final sample_valid)
  - else: x_input<=x_input+1 modulo 256, counter<=0, go to WAIT
- Sweep length and timing:
  - Each point occupies LATENCY+1 cycles; x_input is stable for LATENCY+1 edges before capture.
  - Points per sweep = ((x_end - x_start) mod 256)+1. x_start==x_end gives 1 point.
  - x_end<x_start wraps through 255->0.
- Outputs held: x_input holds its last value in DONE. Results and maxima hold until the next accepted start.
- start while busy: ignored, no effect on any register.

Test Plan:
- LATENCY=2, start pulse with x_start=180, x_end=183, ideal model (all y equal) -> four sample_valid pulses 3 cycles apart with sample_x 180..183. done and busy=0 appear 12 cycles after the start edge. All err/max outputs 0.
- Model with linear = exact+3 at x=181 and exact+5 at x=182, quadratic = exact-2 at x=183 -> max_err_lin=5, max_x_lin=182; max_err_quad=2, max_x_quad=183. err_lin=5 on the x=182 pulse only.
- Wrap: x_start=254, x_end=1 -> sample_x sequence 254,255,0,1, then done.
- Single point: x_start=x_end=7 -> exactly one sample_valid (sample_x=7), done on the same cycle.
- Tie: error 4 at x=10 and again at x=12 -> max_x_lin stays 10. A start pulse mid-sweep is ignored (sequence unchanged).
- rst asserted during WAIT of the 2nd point -> next cycle all outputs 0 and state IDLE. A later start runs a clean full sweep with cleared maxima.
